// File: rtl/nco_bank.sv
// Multi-channel phase-accumulator NCO bank with shadowed per-channel increments/phases and a commit FSM.
// Optional feature: define NCO_DITHER_EN to add an LFSR dither bit to every channel increment.
module nco_bank #(
    parameter int               NCH      = 4,
    parameter int               ACC_W    = 24,
    parameter int               CTRL_W   = 24,
    parameter int               CTRL_SH  = 8,
    parameter logic [ACC_W-1:0] BASE_INC = ACC_W'(1 << 16),
    parameter int               CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic signed [CTRL_W-1:0] ctrl,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [CH_W-1:0]          cfg_ch,
    input  logic [ACC_W-1:0]         cfg_inc,
    input  logic [ACC_W-1:0]         cfg_phase,
    input  logic                     cfg_commit,
    input  logic                     phase_sync,
    output logic [NCH-1:0]           clk_out,
    output logic [NCH-1:0]           wrap,
    output logic [NCH*ACC_W-1:0]     phase_acc
);

    typedef enum logic {
        ST_IDLE,
        ST_COMMIT
    } state_e;

    localparam logic signed [ACC_W:0] NYQ = {2'b01, {(ACC_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q          [NCH];
    logic [ACC_W-1:0] shadow_inc_q   [NCH];
    logic [ACC_W-1:0] shadow_phase_q [NCH];
    logic [ACC_W-1:0] active_inc_q   [NCH];
    logic [ACC_W-1:0] inc_d          [NCH];
    logic [NCH-1:0]   wrap_q;
    logic             cfg_fire;

    logic signed [ACC_W-1:0] ctrl_ext;
    logic signed [ACC_W-1:0] ctrl_scaled;

    assign ctrl_ext    = ctrl;
    assign ctrl_scaled = ctrl_ext >>> CTRL_SH;

`ifdef NCO_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else if (ena) begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end
`endif

    // Signed ACC_W+1 sum so negative trims are seen before the clamp to [1, Nyquist].
    always_comb begin
        logic signed [ACC_W:0] inc_s;
        inc_s = '0;
        for (int c = 0; c < NCH; c++) begin
            inc_s = $signed({1'b0, active_inc_q[c]}) + $signed({ctrl_scaled[ACC_W-1], ctrl_scaled});
`ifdef NCO_DITHER_EN
            inc_s = inc_s + $signed({{ACC_W{1'b0}}, lfsr_q[0]});
`endif
            if (inc_s <= 0) begin
                inc_d[c] = ACC_W'(1);
            end else if (inc_s > NYQ) begin
                inc_d[c] = NYQ[ACC_W-1:0];
            end else begin
                inc_d[c] = inc_s[ACC_W-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cfg_ready = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_commit) state_d = ST_COMMIT;
            end
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign cfg_fire = cfg_valid && cfg_ready;

    // NOTE: the shadow/active arrays carry architectural reset values, so they sit in the async reset branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wrap_q  <= '0;
            for (int c = 0; c < NCH; c++) begin
                acc_q[c]          <= '0;
                shadow_inc_q[c]   <= BASE_INC;
                shadow_phase_q[c] <= '0;
                active_inc_q[c]   <= BASE_INC;
            end
        end else begin
            state_q <= state_d;
            for (int c = 0; c < NCH; c++) begin
                if (phase_sync) begin
                    acc_q[c]  <= shadow_phase_q[c];
                    wrap_q[c] <= 1'b0;
                end else if (ena) begin
                    {wrap_q[c], acc_q[c]} <= {1'b0, acc_q[c]} + {1'b0, inc_d[c]};
                end else begin
                    wrap_q[c] <= 1'b0;
                end
                // Out-of-range channel numbers complete the handshake but match no channel.
                if (cfg_fire && (int'(cfg_ch) == c)) begin
                    shadow_inc_q[c]   <= cfg_inc;
                    shadow_phase_q[c] <= cfg_phase;
                end
                if (state_q == ST_COMMIT) begin
                    active_inc_q[c] <= shadow_inc_q[c];
                end
            end
        end
    end

    always_comb begin
        clk_out   = '0;
        phase_acc = '0;
        for (int c = 0; c < NCH; c++) begin
            clk_out[c]                    = acc_q[c][ACC_W-1];
            phase_acc[c*ACC_W +: ACC_W]   = acc_q[c];
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_nco_bank.sv
// Self-checking bench for nco_bank: constant vector table, directed corner sequences and
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_nco_bank;

    localparam int     NCH   = 4;
    localparam int     ACC_W = 24;
    localparam longint MOD   = 64'd1 << ACC_W;
    localparam longint NYQ   = 64'd1 << (ACC_W - 1);

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   ena;
    logic signed [23:0]     ctrl;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [1:0]             cfg_ch;
    logic [23:0]            cfg_inc;
    logic [23:0]            cfg_phase;
    logic                   cfg_commit;
    logic                   phase_sync;
    logic [NCH-1:0]         clk_out;
    logic [NCH-1:0]         wrap;
    logic [NCH*ACC_W-1:0]   phase_acc;

    int n_checks = 0;
    int n_errors = 0;

    nco_bank dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ctrl       (ctrl),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_inc    (cfg_inc),
        .cfg_phase  (cfg_phase),
        .cfg_commit (cfg_commit),
        .phase_sync (phase_sync),
        .clk_out    (clk_out),
        .wrap       (wrap),
        .phase_acc  (phase_acc)
    );

    always #5 clk = ~clk;

    // Reference model state: plain integers, one entry per channel.
    longint m_acc [NCH];
    longint m_sinc[NCH];
    longint m_sph [NCH];
    longint m_ainc[NCH];
    bit     m_wrap[NCH];
    bit     m_commit;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic longint eff_inc(int c);
        longint s;
        s = m_ainc[c] + (longint'(ctrl) >>> 8);
        if (s <= 0) return 1;
        if (s > NYQ) return NYQ;
        return s;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_acc[c]  = 0;
            m_sinc[c] = 64'h10000;
            m_ainc[c] = 64'h10000;
            m_sph[c]  = 0;
            m_wrap[c] = 0;
        end
        m_commit = 0;
    endfunction

    function automatic void model_update();
        longint n_acc[NCH];
        bit     fire;
        fire = cfg_valid && !m_commit;
        for (int c = 0; c < NCH; c++) begin
            if (phase_sync) begin
                n_acc[c]  = m_sph[c];
                m_wrap[c] = 0;
            end else if (ena) begin
                longint t;
                t         = m_acc[c] + eff_inc(c);
                m_wrap[c] = (t >= MOD);
                n_acc[c]  = t % MOD;
            end else begin
                n_acc[c]  = m_acc[c];
                m_wrap[c] = 0;
            end
        end
        if (m_commit) begin
            for (int c = 0; c < NCH; c++) m_ainc[c] = m_sinc[c];
        end
        if (fire && int'(cfg_ch) < NCH) begin
            m_sinc[cfg_ch] = longint'(cfg_inc);
            m_sph[cfg_ch]  = longint'(cfg_phase);
        end
        m_commit = m_commit ? 1'b0 : cfg_commit;
        for (int c = 0; c < NCH; c++) m_acc[c] = n_acc[c];
    endfunction

    task automatic compare_model();
        logic [NCH*ACC_W-1:0] e_acc;
        logic [NCH-1:0]       e_wrap;
        logic [NCH-1:0]       e_clk;
        for (int c = 0; c < NCH; c++) begin
            e_acc[c*ACC_W +: ACC_W] = m_acc[c][ACC_W-1:0];
            e_wrap[c]               = m_wrap[c];
            e_clk[c]                = (m_acc[c] >= NYQ);
        end
        check("model_phase_acc", phase_acc, e_acc);
        check("model_wrap", wrap, e_wrap);
        check("model_clk_out", clk_out, e_clk);
        check("model_cfg_ready", cfg_ready, !m_commit);
    endtask

    task automatic idle_inputs();
        ena = 0; ctrl = '0; cfg_valid = 0; cfg_ch = '0; cfg_inc = '0;
        cfg_phase = '0; cfg_commit = 0; phase_sync = 0;
    endtask

    // Inputs set by the caller are consumed at the next rising edge; outputs sampled 1 time unit later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst_phase_acc", phase_acc, '0);
        check("rst_wrap", wrap, '0);
        check("rst_clk_out", clk_out, '0);
        check("rst_cfg_ready", cfg_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic                  ena;
        logic signed [23:0]    ctrl;
        logic                  cfg_valid;
        logic [1:0]            ch;
        logic [23:0]           inc;
        logic [23:0]           phase;
        logic                  commit;
        logic                  sync;
        logic [NCH-1:0][23:0]  exp_acc;
        logic                  exp_ready;
    } vec_t;

    function automatic vec_t mk(logic e, logic signed [23:0] ct, logic v, logic [1:0] ch,
                                logic [23:0] inc, logic [23:0] ph, logic cm, logic sy,
                                logic [NCH-1:0][23:0] ea, logic er);
        vec_t r;
        r.ena = e; r.ctrl = ct; r.cfg_valid = v; r.ch = ch; r.inc = inc; r.phase = ph;
        r.commit = cm; r.sync = sy; r.exp_acc = ea; r.exp_ready = er;
        return r;
    endfunction

    vec_t vt[10];

    initial begin
        int first_w, second_w, n_high, mism;
        longint a0;

        rst_n = 1'b0;
        idle_inputs();
        model_reset();

        // Expected accumulators written {ch3, ch2, ch1, ch0}.
        vt[0] = mk(1, 24'sh000000, 0, 0, 0, 0, 0, 0,
                   {24'h010000, 24'h010000, 24'h010000, 24'h010000}, 1);
        vt[1] = mk(1, -24'sh800000, 0, 0, 0, 0, 0, 0,
                   {24'h018000, 24'h018000, 24'h018000, 24'h018000}, 1);
        vt[2] = mk(0, 24'sh000000, 0, 0, 0, 0, 0, 0,
                   {24'h018000, 24'h018000, 24'h018000, 24'h018000}, 1);
        vt[3] = mk(1, 24'sh7FFFFF, 0, 0, 0, 0, 0, 0,
                   {24'h02FFFF, 24'h02FFFF, 24'h02FFFF, 24'h02FFFF}, 1);
        vt[4] = mk(1, 24'sh000000, 1, 1, 24'h020000, 24'h000100, 1, 0,
                   {24'h03FFFF, 24'h03FFFF, 24'h03FFFF, 24'h03FFFF}, 0);
        vt[5] = mk(1, 24'sh000000, 0, 0, 0, 0, 0, 0,
                   {24'h04FFFF, 24'h04FFFF, 24'h04FFFF, 24'h04FFFF}, 1);
        vt[6] = mk(1, 24'sh000000, 0, 0, 0, 0, 0, 0,
                   {24'h05FFFF, 24'h05FFFF, 24'h06FFFF, 24'h05FFFF}, 1);
        vt[7] = mk(1, 24'sh000000, 1, 2, 24'h010000, 24'h800000, 0, 1,
                   {24'h000000, 24'h000000, 24'h000100, 24'h000000}, 1);
        vt[8] = mk(0, 24'sh000000, 0, 0, 0, 0, 0, 1,
                   {24'h000000, 24'h800000, 24'h000100, 24'h000000}, 1);
        vt[9] = mk(1, 24'sh000000, 0, 0, 0, 0, 0, 0,
                   {24'h010000, 24'h810000, 24'h020100, 24'h010000}, 1);

        do_reset();

        for (int i = 0; i < 10; i++) begin
            ena = vt[i].ena; ctrl = vt[i].ctrl; cfg_valid = vt[i].cfg_valid; cfg_ch = vt[i].ch;
            cfg_inc = vt[i].inc; cfg_phase = vt[i].phase; cfg_commit = vt[i].commit;
            phase_sync = vt[i].sync;
            step();
            check($sformatf("vec%0d_phase_acc", i), phase_acc, vt[i].exp_acc);
            check($sformatf("vec%0d_cfg_ready", i), cfg_ready, vt[i].exp_ready);
        end

        // Base frequency: 256-cycle period, 50% duty, first wrap at cycle 256.
        do_reset();
        ena = 1;
        first_w = -1; second_w = -1; n_high = 0;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (k <= 512 && clk_out[0]) n_high++;
            if (wrap[0]) begin
                if (first_w < 0) first_w = k;
                else if (second_w < 0) second_w = k;
            end
        end
        check("base_first_wrap", first_w, 256);
        check("base_second_wrap", second_w, 512);
        check("base_duty_high", n_high, 256);

        // Negative trim halves the increment: first wrap at cycle 512.
        do_reset();
        ena = 1; ctrl = -24'sh800000;
        first_w = -1;
        for (int k = 1; k <= 520; k++) begin
            step();
            if (wrap[0] && first_w < 0) first_w = k;
        end
        check("trim_first_wrap", first_w, 512);

        // Lower clamp: increment 1 with a large negative trim still advances by 1.
        do_reset();
        cfg_valid = 1; cfg_ch = 0; cfg_inc = 24'h000001; cfg_commit = 1;
        step();
        idle_inputs();
        step();
        ena = 1; ctrl = -24'sh7FFFFF;
        a0 = longint'(phase_acc[23:0]);
        for (int k = 0; k < 5; k++) step();
        check("clamp_low_delta", longint'(phase_acc[23:0]) - a0, 5);

        // Commit held high is ignored while in COMMIT.
        idle_inputs();
        cfg_commit = 1;
        step();
        check("commit_busy", cfg_ready, 1'b0);
        step();
        check("commit_ignored", cfg_ready, 1'b1);
        cfg_commit = 0;
        step();

        // Half-cycle phase offset on ch2 inverts its clock relative to ch0.
        do_reset();
        cfg_valid = 1; cfg_ch = 2; cfg_inc = 24'h010000; cfg_phase = 24'h800000;
        step();
        idle_inputs();
        phase_sync = 1;
        step();
        check("sync_ch2", phase_acc[2*ACC_W +: ACC_W], 24'h800000);
        check("sync_ch0", phase_acc[23:0], 24'h000000);
        phase_sync = 0; ena = 1;
        mism = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (clk_out[2] !== ~clk_out[0]) mism++;
        end
        check("inverse_clk_mismatches", mism, 0);

        // Upper clamp: 0xFFFFFF limited to Nyquist, clk_out[3] toggles every cycle.
        idle_inputs();
        cfg_valid = 1; cfg_ch = 3; cfg_inc = 24'hFFFFFF; cfg_commit = 1;
        step();
        idle_inputs();
        step();
        ena = 1;
        step();
        mism = 0;
        for (int k = 0; k < 16; k++) begin
            logic prev;
            prev = clk_out[3];
            step();
            if (clk_out[3] === prev) mism++;
        end
        check("nyquist_toggle_mismatches", mism, 0);

        // Reset asserted while in COMMIT discards the pending copy.
        do_reset();
        cfg_valid = 1; cfg_ch = 0; cfg_inc = 24'h123456; cfg_commit = 1; ena = 1;
        step();
        check("pre_reset_busy", cfg_ready, 1'b0);
        #2;
        do_reset();
        ena = 1;
        step();
        check("post_reset_acc0", phase_acc[23:0], 24'h010000);
        step();
        check("post_reset_acc0_b", phase_acc[23:0], 24'h020000);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            ena        = ($urandom_range(0, 7) != 0);
            ctrl       = 24'($urandom);
            cfg_valid  = ($urandom_range(0, 9) < 3);
            cfg_ch     = 2'($urandom);
            cfg_inc    = ($urandom_range(0, 3) == 0) ? 24'($urandom_range(0, 32'h10000))
                                                     : 24'($urandom_range(0, 32'h900000));
            cfg_phase  = 24'($urandom);
            cfg_commit = ($urandom_range(0, 9) == 0);
            phase_sync = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
